// File: rtl/cycle_sequencer_pkg.sv
// Shared subcycle encodings and fetch-address geometry for the cycle sequencer,
// the address nibble mux and any downstream decode/bus blocks.
package cycle_pkg;

    localparam int unsigned StateW      = 3;
    localparam int unsigned NibbleW     = 4;
    localparam int unsigned NibbleCount = 3;
    localparam int unsigned PcMaxW      = NibbleW * NibbleCount;

    typedef logic [StateW-1:0]  subcycle_t;
    typedef logic [NibbleW-1:0] nibble_t;

    // Subcycles of one machine cycle: three address, two memory, three execute.
    localparam subcycle_t StA1 = 3'd0;
    localparam subcycle_t StA2 = 3'd1;
    localparam subcycle_t StA3 = 3'd2;
    localparam subcycle_t StM1 = 3'd3;
    localparam subcycle_t StM2 = 3'd4;
    localparam subcycle_t StX1 = 3'd5;
    localparam subcycle_t StX2 = 3'd6;
    localparam subcycle_t StX3 = 3'd7;

endpackage

// File: rtl/cycle_sequencer_if.sv
// Strobe, fetch-address and bus-status signals of the cycle sequencer.
// The slave side is the sequencer; the master side is the clock generator / host.
interface cycle_sequencer_if
    import cycle_pkg::*;
#(
    parameter int unsigned PC_W = 12
);

    logic            ph1_i;
    logic            ph2_i;
    logic [PC_W-1:0] pc_i;
    logic            halt_req_i;

    subcycle_t       state_o;
    logic            sync_o;
    nibble_t         addr_out_o;
    logic            addr_oe_o;
    logic            fetch_hi_o;
    logic            fetch_lo_o;
    logic            halted_o;

    modport master (
        output ph1_i, ph2_i, pc_i, halt_req_i,
        input  state_o, sync_o, addr_out_o, addr_oe_o, fetch_hi_o, fetch_lo_o, halted_o
    );

    modport slave (
        input  ph1_i, ph2_i, pc_i, halt_req_i,
        output state_o, sync_o, addr_out_o, addr_oe_o, fetch_hi_o, fetch_lo_o, halted_o
    );

endinterface

// File: rtl/cycle_sequencer_addr_nibble_mux.sv
// Picks the fetch-address nibble belonging to the current address subcycle.
// Nibbles lying beyond the configured address width read as zero.
module addr_nibble_mux
    import cycle_pkg::*;
#(
    parameter int unsigned PC_W = 12
) (
    input  logic [PcMaxW-1:0] pc_i,
    input  subcycle_t         state_i,
    output nibble_t           nibble_o
);

    // A1/A2/A3 select low/middle/high nibble; other subcycles yield zero.
    always_comb begin
        nibble_o = '0;
        case (state_i)
            StA1: nibble_o = pc_i[3:0];
            StA2: if (PC_W > 4) nibble_o = pc_i[7:4];
            StA3: if (PC_W > 8) nibble_o = pc_i[11:8];
            default: nibble_o = '0;
        endcase
    end

endmodule

// File: rtl/cycle_sequencer.sv
// Machine-cycle sequencer: steps through A1..X3 on PH2 strobes, drives the
// fetch address one nibble per A-subcycle on PH1 strobes, flags the opcode
// nibble fetches and can park at the X3 boundary on request.
module cycle_sequencer
    import cycle_pkg::*;
#(
    parameter int unsigned PC_W = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    cycle_sequencer_if.slave bus
);

    if ((PC_W == 0) || (PC_W > PcMaxW) || ((PC_W % NibbleW) != 0)) begin : g_pc_w_check
        $error("PC_W must be a nonzero multiple of 4 no larger than 12");
    end

    subcycle_t         state_q, state_d;
    logic              halted_q, halted_d;
    logic              sync_q, sync_d;
    logic [PcMaxW-1:0] pc_q, pc_d;
    nibble_t           addr_q, addr_d;
    logic              oe_q, oe_d;
    logic              fetch_hi_q, fetch_hi_d;
    logic              fetch_lo_q, fetch_lo_d;

    logic [PcMaxW-1:0] pc_ext;
    nibble_t           nibble;

    // Zero-extend the fetch address so unused upper nibbles drive 0.
    always_comb begin
        pc_ext            = '0;
        pc_ext[PC_W-1:0]  = bus.pc_i;
    end

    addr_nibble_mux #(
        .PC_W (PC_W)
    ) u_addr_nibble_mux (
        .pc_i     (pc_q),
        .state_i  (state_q),
        .nibble_o (nibble)
    );

    // Next state: PH2 wins over PH1; with neither strobe everything holds
    // except the one-clock fetch flags, which always self-clear.
    always_comb begin
        state_d    = state_q;
        halted_d   = halted_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        oe_d       = oe_q;
        fetch_hi_d = 1'b0;
        fetch_lo_d = 1'b0;
        if (bus.ph2_i) begin
            if (state_q == StX3) begin
                // Cycle boundary: park while a halt is requested, else start a new cycle.
                if (bus.halt_req_i) begin
                    halted_d = 1'b1;
                end else begin
                    halted_d = 1'b0;
                    state_d  = StA1;
                    pc_d     = pc_ext;
                end
            end else begin
                state_d    = state_q + 3'd1;
                fetch_hi_d = (state_q == StM1);
                fetch_lo_d = (state_q == StM2);
            end
        end else if (bus.ph1_i) begin
            case (state_q)
                StA1: begin
                    addr_d = nibble;
                    oe_d   = 1'b1;
                end
                StA2, StA3: addr_d = nibble;
                StM1:       oe_d   = 1'b0;
                default:    ;
            endcase
        end
        sync_d = (state_d == StX3) && !halted_d;
    end

    // State and output registers; reset parks at X3 ready for the first PH2.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StX3;
            halted_q   <= 1'b0;
            sync_q     <= 1'b1;
            pc_q       <= '0;
            addr_q     <= '0;
            oe_q       <= 1'b0;
            fetch_hi_q <= 1'b0;
            fetch_lo_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            halted_q   <= halted_d;
            sync_q     <= sync_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            oe_q       <= oe_d;
            fetch_hi_q <= fetch_hi_d;
            fetch_lo_q <= fetch_lo_d;
        end
    end

    assign bus.state_o    = state_q;
    assign bus.sync_o     = sync_q;
    assign bus.addr_out_o = addr_q;
    assign bus.addr_oe_o  = oe_q;
    assign bus.fetch_hi_o = fetch_hi_q;
    assign bus.fetch_lo_o = fetch_lo_q;
    assign bus.halted_o   = halted_q;

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 Parameter PC_W, default 12, fetch address width; SHALL be a multiple of 4 and at most 12.
REQ-002 CLK  in  1  system clock, rising-edge active; the only clock.
REQ-003 RST  in  1  asynchronous, active-low reset.
REQ-004 PH1  in  1  phase-1 strobe from clock generator, one CLK wide, CLK-synchronous.
REQ-005 PH2  in  1  phase-2 strobe from clock generator, one CLK wide, CLK-synchronous.
REQ-006 PC  in  PC_W  next fetch address.
REQ-007 HALT_REQ  in  1  request to stop at machine-cycle boundary.
REQ-008 STATE  out  3  current subcycle: A1=0 A2=1 A3=2 M1=3 M2=4 X1=5 X2=6 X3=7.
REQ-009 SYNC  out  1  high while STATE=X3 and not halted.
REQ-010 ADDR_OUT  out  4  address nibble driven to the bus.
REQ-011 ADDR_OE  out  1  bus output enable for ADDR_OUT.
REQ-012 FETCH_HI  out  1  one-CLK strobe: opcode-high nibble valid on bus.
REQ-013 FETCH_LO  out  1  one-CLK strobe: opcode-low nibble valid on bus.
REQ-014 HALTED  out  1  high while held at the cycle boundary.

Function
REQ-015 All outputs SHALL be registered; the block SHALL change state only on CLK edges where PH1 or PH2 is sampled high.
REQ-016 STATE SHALL advance by one (X3 wraps to A1) on each CLK edge where PH2=1, except in halt.
REQ-017 PH1=1 and PH2=1 together SHALL be treated as PH2 only; PH1 is ignored that edge.
REQ-018 On the X3->A1 transition, PC SHALL be latched into an internal register; PC changes at other times SHALL have no effect on the current cycle.
REQ-019 On the PH1 edge in A1/A2/A3, ADDR_OUT SHALL load latched PC[3:0]/[7:4]/[11:8] respectively; bits at or beyond PC_W SHALL drive 0.
REQ-020 ADDR_OE SHALL rise on the PH1 edge in A1 and fall on the PH1 edge in M1; ADDR_OUT SHALL hold its value between updates.
REQ-021 FETCH_HI SHALL pulse high for exactly one CLK on the edge after the PH2 sample that ends M1; FETCH_LO likewise for M2.
REQ-022 HALT_REQ SHALL be sampled only on the PH2 edge in X3; if 1, STATE SHALL stay X3, HALTED=1, SYNC=0 from the next CLK.
REQ-023 While halted, the first PH2 edge with HALT_REQ=0 SHALL enter A1, clear HALTED, latch PC, and restore normal sequencing.
REQ-024 HALT_REQ asserted outside X3 SHALL not disturb the current cycle; it takes effect at the next X3 PH2 edge if still high.
REQ-025 Absence of PH1/PH2 strobes SHALL freeze all state and outputs indefinitely.

Reset
REQ-026 RST low SHALL immediately force STATE=X3, SYNC=1, ADDR_OUT=0, ADDR_OE=0, FETCH_HI=0, FETCH_LO=0, HALTED=0, latched PC=0.
REQ-027 Reset mid-cycle SHALL abandon the cycle; the first PH2 after release SHALL enter A1 with the PC then present.
REQ-028 Reset release SHALL require no strobe alignment; strobes in the release cycle are honoured normally.

Structure
REQ-029 Subcycle encodings (A1..X3) and the nibble count SHALL reside in a shared package, cycle_pkg, for reuse by decode and bus blocks.
REQ-030 The block SHALL be one module plus one sub-module, addr_nibble_mux, selecting the PC nibble from STATE.

Verification
REQ-031 Reset, PC=0xABC, alternate PH1/PH2 each 4 CLK -> STATE 7,0,1,...,7,0; ADDR_OUT C,B,A in A1-A3; ADDR_OE high A1 PH1 to M1 PH1.
REQ-032 Continuous cycles -> FETCH_HI and FETCH_LO each exactly one CLK per machine cycle; SYNC high only in X3.
REQ-033 HALT_REQ=1 before X3 PH2 -> HALTED=1, STATE=7, SYNC=0 across 20 strobes; drop HALT_REQ -> next PH2 gives STATE=0, HALTED=0.
REQ-034 RST pulsed low during M2 -> outputs match REQ-026 immediately; next PH2 -> STATE=0 with new PC latched.
REQ-035 PH1 and PH2 high on the same CLK in A1 -> STATE advances to A2, ADDR_OUT unchanged.
REQ-036 PC changed from 0x123 to 0x456 during A2 -> bus shows 3,2,1; next cycle shows 6,5,4.
